// File: rtl/mem_pkg.sv
// Shared types for the banked SRAM controller: FSM states,
// response control fields and the byte-enable mask helper.
package mem_pkg;

  localparam int MAX_BE = 128;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Response payload is {rsp_ctrl_t, rdata}
  typedef struct packed {
    logic err;
    logic was_write;
  } rsp_ctrl_t;

  localparam int RSP_CTRL_W = $bits(rsp_ctrl_t);

  function automatic logic [8*MAX_BE-1:0] be_mask(
    input logic [MAX_BE-1:0] be
  );
    logic [8*MAX_BE-1:0] m;
    for (int i = 0; i < MAX_BE; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/rsp_fifo2.sv
// 2-entry response FIFO; slot0 is always the head entry.
// Ports: push_valid/push_data in, pop_valid/pop_ready/pop_data out, count.
module rsp_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic             pop;
  logic             push;

  assign pop_valid = (count != 2'd0);
  assign pop_data  = slot0;
  assign pop       = pop_valid && pop_ready;
  assign push      = push_valid && ((count != 2'd2) || pop);

  // The head is not cleared on the last pop so outputs hold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_data;
          else               slot1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            slot0 <= slot1;
            slot1 <= push_data;
          end else begin
            slot0 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/banked_sram_ctrl.sv
// Single-port SRAM bank with zero-init sequencer and in-order responses.
// Ports: clock/reset_n/clear, req_* channel, rsp_* channel, init_done.
module banked_sram_ctrl
  import mem_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 11,
  parameter  int DEPTH      = 2048,
  localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  chip_select,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [BE_WIDTH-1:0]   req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_was_write,
  output logic                  init_done
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = RSP_CTRL_W + DATA_WIDTH;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W =
    (ADDR_WIDTH + 1)'(DEPTH);

  state_t                state;
  logic [IW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]            fifo_cnt;
  logic                  accept;
  logic                  in_range;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] push_rdata;
  rsp_ctrl_t             push_ctrl;
  rsp_ctrl_t             head_ctrl;
  logic [PW-1:0]         head;

  assign req_ready = (state == RUN) && chip_select
                  && (fifo_cnt < 2'd2) && !clear;
  assign accept    = req_valid && req_ready;
  assign in_range  = ({1'b0, req_addr} < DEPTH_W);
  assign idx       = req_addr[IW-1:0];
  assign mask      = DATA_WIDTH'(be_mask(MAX_BE'(req_be)));
  assign rd_word   = mem[idx];
  assign init_done = (state == RUN);

  assign push_ctrl.err       = !in_range;
  assign push_ctrl.was_write = req_we;
  assign push_rdata = (!req_we && in_range) ? rd_word : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
      cnt   <= '0;
    end else if (clear) begin
      state <= INIT;
      cnt   <= '0;
    end else if (state == INIT) begin
      if (cnt == LAST) begin
        state <= RUN;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Array itself is never reset; INIT clears it word by word.
  always_ff @(posedge clock) begin
    if (state == INIT) begin
      mem[cnt] <= '0;
    end else if (accept && req_we && in_range) begin
      mem[idx] <= (mem[idx] & ~mask) | (req_wdata & mask);
    end
  end

  rsp_fifo2 #(.WIDTH(PW)) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push_valid (accept),
    .push_data  ({push_ctrl, push_rdata}),
    .pop_valid  (rsp_valid),
    .pop_ready  (rsp_ready),
    .pop_data   (head),
    .count      (fifo_cnt)
  );

  assign {head_ctrl, rsp_rdata} = head;
  assign rsp_err       = head_ctrl.err;
  assign rsp_was_write = head_ctrl.was_write;

endmodule

// File: doc/banked_sram_ctrl.md
Name: banked_sram_ctrl

Overview:
- Parametrised single-port synchronous RAM with a valid/ready request channel and a valid/ready response channel.
- Supports byte-enable writes and in-order responses for both reads and writes.
- Contains a hardware zero-initialisation sequencer and a 2-entry response buffer, so consumer backpressure never drops data.
- Used as the general-purpose data/program memory bank behind the bus decoder; chip_select comes from the decoder.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 11, request address width.
- DEPTH, 2048, number of words; 1 <= DEPTH <= 2**ADDR_WIDTH.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width; localparam, not overridable.

Ports:
- clock  in  1  rising-edge clock for all state.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  pulse; restarts the zero-initialisation sequence.
- chip_select  in  1  bank selected; new requests are accepted only when high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on a clock edge where req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_be  in  BE_WIDTH  byte enables; bit i enables byte [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed on a clock edge where rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  address >= DEPTH.
- rsp_was_write  out  1  response belongs to a write.
- init_done  out  1  high in RUN state.

Behaviour:
- Reset (async, reset_n low):
  - FSM goes to INIT and the init counter goes to 0.
  - Response FIFO is emptied.
  - Outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_was_write=0, init_done=0.
  - Memory array is not reset.
- FSM states:
  - INIT: one word per cycle, mem[cnt] <= 0, cnt++. After the edge that writes DEPTH-1, go to RUN. init_done rises exactly DEPTH cycles after reset_n deasserts.
  - RUN: normal operation.
  - Transitions: clear sampled high in RUN -> INIT with cnt=0. clear sampled high in INIT -> cnt restarts at 0.
- req_ready = (state==RUN) && chip_select && (fifo_count < 2) && !clear.
  - Registered-state only; no combinational path from rsp_ready.
- Accepted write, addr < DEPTH:
  - Enabled bytes are written at the accept edge; other bytes are unchanged.
  - Pushes {rdata=0, err=0, was_write=1}.
- Accepted write, addr >= DEPTH: memory untouched; pushes {0, err=1, was_write=1}.
- Accepted read, addr < DEPTH: mem[addr] is read at the accept edge and pushed with {err=0, was_write=0}. req_be is ignored.
- Accepted read, addr >= DEPTH: pushes {0, err=1, was_write=0}.
- Latency: rsp_valid is high in the cycle after acceptance if the FIFO was empty.
- Throughput: 1 request per cycle while rsp_ready is held high.
- Ordering: responses are strictly in acceptance order.
- Read-after-write to the same address on the next cycle returns the new data. Single port, so no same-edge conflict is possible.
- FIFO (2 entries):
  - Push and pop on the same edge keeps the count.
  - rsp_* outputs present the head entry and hold stable while rsp_valid && !rsp_ready.
- chip_select low: no new accepts; queued responses still drain. Response outputs hold their last value; no X is driven.
- clear in RUN:
  - Buffered responses are still delivered.
  - Stale read data already in the FIFO stays as captured.
  - No request is accepted in the clear cycle.
- Reset mid-operation: in-flight and buffered responses are discarded; the FSM re-enters INIT.

Decomposition:
- Shared package, mem_pkg:
  - Response struct/field widths: {err, was_write, rdata}.
  - FSM state encoding: INIT=1'b0, RUN=1'b1.
  - Helper function that expands a byte-enable vector to a bit mask.
- One natural sub-module, rsp_fifo2: 2-entry valid/ready FIFO, parameterised on payload width, with a count output.
- Memory array, init sequencer and request logic live in the top module.

Test Plan:
- DEPTH=16: release reset -> init_done rises exactly 16 cycles later. Read addr 5 -> rsp_rdata=0, err=0, one cycle after accept.
- Byte enables: write 0xAABBCCDD be=4'b1111 to addr 3, then write 0x11223344 be=4'b0101. Read addr 3 -> 0xAA22CC44, was_write=0.
- Backpressure: hold rsp_ready=0 and offer 3 reads (addrs 1, 2, 3 preloaded 0x10, 0x20, 0x30) -> 2 accepted, req_ready=0. Release -> 0x10, 0x20 delivered in order, then the third is accepted and returns 0x30.
- Out of range: DEPTH=12, ADDR_WIDTH=4. Write addr 13 -> err=1 and memory unchanged. Read addr 13 -> rdata=0, err=1. Read addr 11 -> err=0.
- Clear and chip_select: write 0xDEADBEEF to addr 2, then pulse clear -> init_done low for DEPTH cycles, then read addr 2 returns 0. With chip_select=0, req_valid=1 -> never accepted, and a queued response still drains.
- Reset mid-burst: assert reset_n=0 with 2 responses buffered -> rsp_valid=0 immediately (async). After release, INIT runs fully and no stale response appears.
